adam_jtag_dtm: RTL

RISC-V debug transport module (spec 0.13): JTAG TAP responder that serves IDCODE, DTMCS and DMI and converts DMI scans into valid/ready requests toward the debug module. It is the target end of the JTAG master behavioural model. It runs entirely in the system clock domain by oversampling the JTAG pins, and sits between the chip JTAG pads and the debug module in the lsdom debug path.

---
 rtl/adam_jtag_dtm.sv | 305 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/adam_jtag_dtm.sv
`default_nettype none
// ============================================================================
// Module   : adam_jtag_dtm
// Purpose  : RISC-V debug transport module (debug spec 0.13). JTAG TAP
//            responder serving IDCODE, DTMCS and DMI, converting DMI scans
//            into valid/ready requests toward the debug module. The JTAG
//            pins are oversampled in the system clock domain.
// Ports    : clk, rst           system clock, synchronous active-high reset
//            jtag_tck/tms/tdi   asynchronous JTAG pins (synchronized here)
//            jtag_tdo           registered JTAG data out
//            dmi_req_*          request channel toward the debug module
//            dmi_rsp_*          response channel from the debug module
// Revision : 1.0 - initial release
// ============================================================================
module adam_jtag_dtm #(
    parameter logic [31:0] IDCODE = 32'h00000001,
    parameter int unsigned ABITS  = 7,
    parameter logic [2:0]  IDLE   = 3'd1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jtag_tck,
    input  logic             jtag_tms,
    input  logic             jtag_tdi,
    output logic             jtag_tdo,
    output logic             dmi_req_valid,
    input  logic             dmi_req_ready,
    output logic [ABITS-1:0] dmi_req_addr,
    output logic [31:0]      dmi_req_data,
    output logic [1:0]       dmi_req_op,
    input  logic             dmi_rsp_valid,
    output logic             dmi_rsp_ready,
    input  logic [31:0]      dmi_rsp_data,
    input  logic [1:0]       dmi_rsp_op
);

    // DR shift register is sized for the longest chain (DMI)
    localparam int unsigned c_dr_w  = ABITS + 34;
    localparam int unsigned c_msb_w = $clog2(c_dr_w);

    localparam logic [c_msb_w-1:0] c_msb_32  = c_msb_w'(31);
    localparam logic [c_msb_w-1:0] c_msb_dmi = c_msb_w'(c_dr_w - 1);
    localparam logic [c_msb_w-1:0] c_msb_byp = '0;
    localparam logic [5:0]         c_abits6  = 6'(ABITS);

    localparam logic [4:0] c_ir_idcode = 5'h01;
    localparam logic [4:0] c_ir_dtmcs  = 5'h10;
    localparam logic [4:0] c_ir_dmi    = 5'h11;

    // IEEE 1149.1 TAP states
    localparam logic [3:0] c_st_tlr      = 4'h0;
    localparam logic [3:0] c_st_rti      = 4'h1;
    localparam logic [3:0] c_st_sel_dr   = 4'h2;
    localparam logic [3:0] c_st_cap_dr   = 4'h3;
    localparam logic [3:0] c_st_sh_dr    = 4'h4;
    localparam logic [3:0] c_st_ex1_dr   = 4'h5;
    localparam logic [3:0] c_st_pause_dr = 4'h6;
    localparam logic [3:0] c_st_ex2_dr   = 4'h7;
    localparam logic [3:0] c_st_upd_dr   = 4'h8;
    localparam logic [3:0] c_st_sel_ir   = 4'h9;
    localparam logic [3:0] c_st_cap_ir   = 4'hA;
    localparam logic [3:0] c_st_sh_ir    = 4'hB;
    localparam logic [3:0] c_st_ex1_ir   = 4'hC;
    localparam logic [3:0] c_st_pause_ir = 4'hD;
    localparam logic [3:0] c_st_ex2_ir   = 4'hE;
    localparam logic [3:0] c_st_upd_ir   = 4'hF;

    // ------------------------------------------------------------------------
    // Pin synchronizers and tck edge detection
    // ------------------------------------------------------------------------
    logic r_tck_meta, r_tck_sync, r_tck_prev;
    logic r_tms_meta, r_tms_sync;
    logic r_tdi_meta, r_tdi_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tck_meta <= 1'b0;
            r_tck_sync <= 1'b0;
            r_tck_prev <= 1'b0;
            r_tms_meta <= 1'b0;
            r_tms_sync <= 1'b0;
            r_tdi_meta <= 1'b0;
            r_tdi_sync <= 1'b0;
        end else begin
            r_tck_meta <= jtag_tck;
            r_tck_sync <= r_tck_meta;
            r_tck_prev <= r_tck_sync;
            r_tms_meta <= jtag_tms;
            r_tms_sync <= r_tms_meta;
            r_tdi_meta <= jtag_tdi;
            r_tdi_sync <= r_tdi_meta;
        end
    end

    logic w_tck_rise, w_tck_fall;
    assign w_tck_rise = r_tck_sync & ~r_tck_prev;
    assign w_tck_fall = ~r_tck_sync & r_tck_prev;

    // ------------------------------------------------------------------------
    // TAP next-state logic
    // ------------------------------------------------------------------------
    logic [3:0] r_state;
    logic [3:0] w_state_nxt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_tlr:      w_state_nxt = r_tms_sync ? c_st_tlr    : c_st_rti;
            c_st_rti:      w_state_nxt = r_tms_sync ? c_st_sel_dr : c_st_rti;
            c_st_sel_dr:   w_state_nxt = r_tms_sync ? c_st_sel_ir : c_st_cap_dr;
            c_st_cap_dr:   w_state_nxt = r_tms_sync ? c_st_ex1_dr : c_st_sh_dr;
            c_st_sh_dr:    w_state_nxt = r_tms_sync ? c_st_ex1_dr : c_st_sh_dr;
            c_st_ex1_dr:   w_state_nxt = r_tms_sync ? c_st_upd_dr : c_st_pause_dr;
            c_st_pause_dr: w_state_nxt = r_tms_sync ? c_st_ex2_dr : c_st_pause_dr;
            c_st_ex2_dr:   w_state_nxt = r_tms_sync ? c_st_upd_dr : c_st_sh_dr;
            c_st_upd_dr:   w_state_nxt = r_tms_sync ? c_st_sel_dr : c_st_rti;
            c_st_sel_ir:   w_state_nxt = r_tms_sync ? c_st_tlr    : c_st_cap_ir;
            c_st_cap_ir:   w_state_nxt = r_tms_sync ? c_st_ex1_ir : c_st_sh_ir;
            c_st_sh_ir:    w_state_nxt = r_tms_sync ? c_st_ex1_ir : c_st_sh_ir;
            c_st_ex1_ir:   w_state_nxt = r_tms_sync ? c_st_upd_ir : c_st_pause_ir;
            c_st_pause_ir: w_state_nxt = r_tms_sync ? c_st_ex2_ir : c_st_pause_ir;
            c_st_ex2_ir:   w_state_nxt = r_tms_sync ? c_st_upd_ir : c_st_sh_ir;
            c_st_upd_ir:   w_state_nxt = r_tms_sync ? c_st_sel_dr : c_st_rti;
            default:       w_state_nxt = c_st_tlr;
        endcase
    end

    // ------------------------------------------------------------------------
    // DMI-side state (declared early; used by the DR capture mux)
    // ------------------------------------------------------------------------
    logic             r_req_valid;
    logic [ABITS-1:0] r_req_addr;
    logic [31:0]      r_req_data;
    logic [1:0]       r_req_op;
    logic [31:0]      r_rsp_data;
    logic [1:0]       r_dmistat;
    logic             r_outstanding;

    // ------------------------------------------------------------------------
    // Data register selection, capture and shift
    // ------------------------------------------------------------------------
    logic [4:0]        r_ir;
    logic [4:0]        r_ir_sr;
    logic [c_dr_w-1:0] r_dr;
    logic              r_upd_dr;
    logic              r_tdo;

    logic [c_msb_w-1:0] w_dr_msb;
    logic [c_dr_w-1:0]  w_dr_capture;
    logic [c_dr_w-1:0]  w_dr_shifted;
    logic [31:0]        w_dtmcs;
    logic [1:0]         w_dmi_status;

    assign w_dmi_status = (r_dmistat != 2'd0) ? r_dmistat :
                          (r_outstanding ? 2'd3 : 2'd0);

    assign w_dtmcs = {17'd0, IDLE, r_dmistat, c_abits6, 4'd1};

    always_comb begin
        w_dr_msb     = c_msb_byp;
        w_dr_capture = '0;
        case (r_ir)
            c_ir_idcode: begin
                w_dr_msb     = c_msb_32;
                w_dr_capture = {{(c_dr_w-32){1'b0}}, IDCODE};
            end
            c_ir_dtmcs: begin
                w_dr_msb     = c_msb_32;
                w_dr_capture = {{(c_dr_w-32){1'b0}}, w_dtmcs};
            end
            c_ir_dmi: begin
                w_dr_msb     = c_msb_dmi;
                w_dr_capture = {r_req_addr, r_rsp_data, w_dmi_status};
            end
            default: begin
                w_dr_msb     = c_msb_byp;
                w_dr_capture = '0;
            end
        endcase
    end

    // tdi enters at the MSB of the currently selected chain length
    always_comb begin
        w_dr_shifted           = {1'b0, r_dr[c_dr_w-1:1]};
        w_dr_shifted[w_dr_msb] = r_tdi_sync;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_tlr;
            r_ir     <= c_ir_idcode;
            r_ir_sr  <= '0;
            r_dr     <= '0;
            r_upd_dr <= 1'b0;
            r_tdo    <= 1'b0;
        end else begin
            if (w_tck_rise) begin
                r_state <= w_state_nxt;
                if (r_state == c_st_cap_ir) begin
                    r_ir_sr <= 5'b00001;
                end else if (r_state == c_st_sh_ir) begin
                    r_ir_sr <= {r_tdi_sync, r_ir_sr[4:1]};
                end
                if (r_state == c_st_cap_dr) begin
                    r_dr <= w_dr_capture;
                end else if (r_state == c_st_sh_dr) begin
                    r_dr <= w_dr_shifted;
                end
            end

            if (r_state == c_st_tlr) begin
                r_ir <= c_ir_idcode;
            end else if (w_tck_rise && (w_state_nxt == c_st_upd_ir)) begin
                r_ir <= r_ir_sr;
            end

            // DR update acts one clk after UpdDR is entered
            r_upd_dr <= w_tck_rise && (w_state_nxt == c_st_upd_dr);

            if ((r_state == c_st_sh_dr) || (r_state == c_st_sh_ir)) begin
                if (w_tck_fall) begin
                    r_tdo <= (r_state == c_st_sh_ir) ? r_ir_sr[0] : r_dr[0];
                end
            end else begin
                r_tdo <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // DTMCS / DMI update and DMI handshakes
    // ------------------------------------------------------------------------
    logic             w_rsp_done;
    logic [1:0]       w_dmistat_eff;
    logic             w_outstanding_eff;
    logic             w_dmi_upd;
    logic             w_dtmcs_upd;
    logic [1:0]       w_upd_op;
    logic [31:0]      w_upd_data;
    logic [ABITS-1:0] w_upd_addr;

    // A response landing in the same cycle as an update is applied first
    assign w_rsp_done        = dmi_rsp_valid && r_outstanding;
    assign w_dmistat_eff     = (w_rsp_done && (dmi_rsp_op != 2'd0)) ? dmi_rsp_op : r_dmistat;
    assign w_outstanding_eff = r_outstanding && !w_rsp_done;

    assign w_dmi_upd   = r_upd_dr && (r_ir == c_ir_dmi);
    assign w_dtmcs_upd = r_upd_dr && (r_ir == c_ir_dtmcs);
    assign w_upd_op    = r_dr[1:0];
    assign w_upd_data  = r_dr[33:2];
    assign w_upd_addr  = r_dr[ABITS+33:34];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_valid   <= 1'b0;
            r_req_addr    <= '0;
            r_req_data    <= '0;
            r_req_op      <= '0;
            r_rsp_data    <= '0;
            r_dmistat     <= '0;
            r_outstanding <= 1'b0;
        end else begin
            if (r_req_valid && dmi_req_ready) begin
                r_req_valid <= 1'b0;
            end

            if (w_rsp_done && (r_req_op == 2'd1)) begin
                r_rsp_data <= dmi_rsp_data;
            end
            r_outstanding <= w_outstanding_eff;
            r_dmistat     <= w_dmistat_eff;

            if (w_dtmcs_upd) begin
                if (r_dr[16] || r_dr[17]) begin
                    r_dmistat <= 2'd0;
                end
                if (r_dr[17]) begin
                    r_outstanding <= 1'b0;
                    r_req_valid   <= 1'b0;
                end
            end

            if (w_dmi_upd && (w_upd_op != 2'd0) && (w_dmistat_eff == 2'd0)) begin
                if (w_outstanding_eff) begin
                    r_dmistat <= 2'd3;
                end else if ((w_upd_op == 2'd1) || (w_upd_op == 2'd2)) begin
                    r_req_addr    <= w_upd_addr;
                    r_req_data    <= w_upd_data;
                    r_req_op      <= w_upd_op;
                    r_outstanding <= 1'b1;
                    r_req_valid   <= 1'b1;
                end
            end
        end
    end

    assign jtag_tdo      = r_tdo;
    assign dmi_req_valid = r_req_valid;
    assign dmi_req_addr  = r_req_addr;
    assign dmi_req_data  = r_req_data;
    assign dmi_req_op    = r_req_op;
    assign dmi_rsp_ready = 1'b1;

endmodule
`default_nettype wire
